// File: rtl/ball_bounce_ctrl_pkg.sv
// Shared types and playfield constants for the ball bounce controller.
package ball_bounce_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_PAUSED = 2'd3
  } state_e;

  localparam int PF_X_MAX = 159;
  localparam int PF_Y_MAX = 119;
  localparam int SPEED_W  = 2;
endpackage

// File: rtl/ball_bounce_ctrl_sync_edge.sv
// Two-flop synchroniser followed by a single-clock rising-edge pulse.
module ball_bounce_ctrl_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/ball_bounce_ctrl.sv
// Wall reflection, bounce counting, speed ramp and game-state sequencing
// for a single ball position generator.
module ball_bounce_ctrl
  import ball_bounce_ctrl_pkg::*;
#(
  parameter int X_MAX             = PF_X_MAX,
  parameter int Y_MAX             = PF_Y_MAX,
  parameter int SPEED_INIT        = 3,
  parameter int BOUNCES_PER_LEVEL = 8,
  parameter int SERVE_FRAMES      = 60
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic [7:0]         x,
  input  logic [7:0]         y,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  output logic               dir_x,
  output logic               dir_y,
  output logic [SPEED_W-1:0] speed,
  output logic               run,
  output logic               bounce,
  output logic [15:0]        bounce_count,
  output logic [1:0]         state_o
);
  localparam int LW = $clog2(BOUNCES_PER_LEVEL + 1);
  localparam int SW = $clog2(SERVE_FRAMES + 1);

  state_e             state_q, state_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               run_q, run_d, bounce_q, bounce_d, toggle_q, toggle_d;
  logic [15:0]        bcnt_q, bcnt_d;
  logic [LW-1:0]      lvl_q, lvl_d;
  logic [SW-1:0]      serve_q, serve_d;
  logic               start_rise, pause_rise, flip_x, flip_y;

  ball_bounce_ctrl_sync_edge u_sync_start (
    .clk(clk), .reset_n(reset_n), .d_i(start), .rise_o(start_rise));
  ball_bounce_ctrl_sync_edge u_sync_pause (
    .clk(clk), .reset_n(reset_n), .d_i(pause), .rise_o(pause_rise));

  // >= on the far walls also catches positions that wrapped past the limit
  assign flip_x = (x == 8'd0 && !dir_x_q) || (x >= 8'(X_MAX) && dir_x_q);
  assign flip_y = (y == 8'd0 && !dir_y_q) || (y >= 8'(Y_MAX) && dir_y_q);

  always_comb begin
    state_d  = state_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    speed_d  = speed_q;
    run_d    = run_q;
    bounce_d = 1'b0;
    toggle_d = toggle_q;
    bcnt_d   = bcnt_q;
    lvl_d    = lvl_q;
    serve_d  = serve_q;
    if (stop) begin
      state_d = ST_IDLE;
      run_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          run_d = 1'b0;
          if (start_rise) begin
            state_d  = ST_SERVE;
            speed_d  = SPEED_W'(SPEED_INIT);
            bcnt_d   = '0;
            lvl_d    = '0;
            serve_d  = '0;
            dir_x_d  = toggle_q;
            dir_y_d  = 1'b1;
            toggle_d = ~toggle_q;
          end
        end
        ST_SERVE: begin
          run_d = 1'b0;
          if (frame_tick) begin
            if (serve_q == SW'(SERVE_FRAMES - 1)) begin
              state_d = ST_PLAY;
              run_d   = 1'b1;
            end else begin
              serve_d = serve_q + SW'(1);
            end
          end
        end
        ST_PLAY: begin
          run_d = 1'b1;
          if (pause_rise) begin
            state_d = ST_PAUSED;
            run_d   = 1'b0;
          end
          if (flip_x) dir_x_d = ~dir_x_q;
          if (flip_y) dir_y_d = ~dir_y_q;
          // a corner flips both axes but is still a single bounce
          if (flip_x || flip_y) begin
            bounce_d = 1'b1;
            if (bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
            if (lvl_q == LW'(BOUNCES_PER_LEVEL - 1)) begin
              lvl_d = '0;
              if (speed_q != '0) speed_d = speed_q - SPEED_W'(1);
            end else begin
              lvl_d = lvl_q + LW'(1);
            end
          end
        end
        ST_PAUSED: begin
          run_d = 1'b0;
          if (pause_rise) begin
            state_d = ST_PLAY;
            run_d   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      speed_q  <= SPEED_W'(SPEED_INIT);
      run_q    <= 1'b0;
      bounce_q <= 1'b0;
      toggle_q <= 1'b0;
      bcnt_q   <= '0;
      lvl_q    <= '0;
      serve_q  <= '0;
    end else begin
      state_q  <= state_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      speed_q  <= speed_d;
      run_q    <= run_d;
      bounce_q <= bounce_d;
      toggle_q <= toggle_d;
      bcnt_q   <= bcnt_d;
      lvl_q    <= lvl_d;
      serve_q  <= serve_d;
    end
  end

  assign dir_x        = dir_x_q;
  assign dir_y        = dir_y_q;
  assign speed        = speed_q;
  assign run          = run_q;
  assign bounce       = bounce_q;
  assign bounce_count = bcnt_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_ball_bounce_ctrl.sv
// Directed bench for ball_bounce_ctrl: vector table in PLAY plus sequences.
module tb_ball_bounce_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [7:0]  x = 8'd80, y = 8'd60;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic        dir_x, dir_y, run, bounce;
  logic [1:0]  speed, state_o;
  logic [15:0] bounce_count;

  int n_cmp = 0;
  int n_err = 0;

  ball_bounce_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .x(x), .y(y),
    .start(start), .pause(pause), .stop(stop), .dir_x(dir_x), .dir_y(dir_y),
    .speed(speed), .run(run), .bounce(bounce), .bounce_count(bounce_count),
    .state_o(state_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic        edx;
    logic        edy;
    logic        eb;
    logic [15:0] ecnt;
    logic [1:0]  espd;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic serve_to_play();
    for (int i = 0; i < 59; i++) begin
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0; cyc(1);
    end
    check("serve_59_state", state_o, 2'd1);
    check("serve_59_run", run, 1'b0);
    frame_tick = 1'b1; cyc(1);
    frame_tick = 1'b0;
    check("serve_60_state", state_o, 2'd2);
    check("serve_60_run", run, 1'b1);
  endtask

  int  bad;
  int  pulses;
  logic bx;

  initial begin
    vecs[0]  = '{8'd80,  8'd60,  1'b0, 1'b1, 1'b0, 16'd0, 2'd3};
    vecs[1]  = '{8'd0,   8'd60,  1'b1, 1'b1, 1'b1, 16'd1, 2'd3};
    vecs[2]  = '{8'd0,   8'd60,  1'b1, 1'b1, 1'b0, 16'd1, 2'd3};
    vecs[3]  = '{8'd80,  8'd60,  1'b1, 1'b1, 1'b0, 16'd1, 2'd3};
    vecs[4]  = '{8'd159, 8'd60,  1'b0, 1'b1, 1'b1, 16'd2, 2'd3};
    vecs[5]  = '{8'd159, 8'd60,  1'b0, 1'b1, 1'b0, 16'd2, 2'd3};
    vecs[6]  = '{8'd80,  8'd0,   1'b0, 1'b1, 1'b0, 16'd2, 2'd3};
    vecs[7]  = '{8'd80,  8'd119, 1'b0, 1'b0, 1'b1, 16'd3, 2'd3};
    vecs[8]  = '{8'd80,  8'd0,   1'b0, 1'b1, 1'b1, 16'd4, 2'd3};
    vecs[9]  = '{8'd0,   8'd119, 1'b1, 1'b0, 1'b1, 16'd5, 2'd3};
    vecs[10] = '{8'd0,   8'd119, 1'b1, 1'b0, 1'b0, 16'd5, 2'd3};
    vecs[11] = '{8'd159, 8'd0,   1'b0, 1'b1, 1'b1, 16'd6, 2'd3};
    vecs[12] = '{8'd200, 8'd60,  1'b0, 1'b1, 1'b0, 16'd6, 2'd3};
    vecs[13] = '{8'd0,   8'd60,  1'b1, 1'b1, 1'b1, 16'd7, 2'd3};
    vecs[14] = '{8'd200, 8'd60,  1'b0, 1'b1, 1'b1, 16'd8, 2'd2};
    vecs[15] = '{8'd80,  8'd130, 1'b0, 1'b0, 1'b1, 16'd9, 2'd2};

    // reset and idle
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
    check("rst_dir_x", dir_x, 1'b1);
    check("rst_dir_y", dir_y, 1'b1);
    check("rst_speed", speed, 2'd3);
    check("rst_run", run, 1'b0);
    check("rst_bcnt", bounce_count, 16'd0);
    check("rst_state", state_o, 2'd0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (state_o !== 2'd0 || run !== 1'b0 || dir_x !== 1'b1 || speed !== 2'd3 || bounce !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);

    // first serve
    start = 1'b1;
    cyc(2);
    check("start_lat_2", state_o, 2'd0);
    cyc(1);
    check("start_lat_3", state_o, 2'd1);
    check("serve1_dir_x", dir_x, 1'b0);
    check("serve1_dir_y", dir_y, 1'b1);
    check("serve1_run", run, 1'b0);
    serve_to_play();

    // vector table in PLAY
    foreach (vecs[i]) begin
      x = vecs[i].vx; y = vecs[i].vy;
      cyc(1);
      check($sformatf("vec%0d_dir_x", i), dir_x, vecs[i].edx);
      check($sformatf("vec%0d_dir_y", i), dir_y, vecs[i].edy);
      check($sformatf("vec%0d_bounce", i), bounce, vecs[i].eb);
      check($sformatf("vec%0d_bcnt", i), bounce_count, vecs[i].ecnt);
      check($sformatf("vec%0d_speed", i), speed, vecs[i].espd);
    end

    // corners with hold: dir is (0,0) here
    x = 8'd0; y = 8'd0;
    cyc(1);
    check("corner_tl_bcnt", bounce_count, 16'd10);
    x = 8'd159; y = 8'd119;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1);
      if (bounce === 1'b1) pulses++;
    end
    check("corner_br_pulses", pulses, 1);
    check("corner_br_dir_x", dir_x, 1'b0);
    check("corner_br_dir_y", dir_y, 1'b0);
    check("corner_br_bcnt", bounce_count, 16'd11);

    // speed ramp: bounce every clock by alternating walls
    y = 8'd60;
    bx = 1'b0;
    for (int n = 11; n < 40; n++) begin
      x = bx ? 8'd159 : 8'd0;
      bx = ~bx;
      cyc(1);
      if (n == 15) check("ramp16_speed", speed, 2'd1);
      if (n == 23) check("ramp24_speed", speed, 2'd0);
    end
    x = 8'd80;
    cyc(1);
    check("ramp40_speed", speed, 2'd0);
    check("ramp40_bcnt", bounce_count, 16'd40);
    check("ramp40_dir_x", dir_x, 1'b1);

    // pause: wall position while paused must not flip
    pause = 1'b1;
    cyc(3);
    check("pause_state", state_o, 2'd3);
    check("pause_run", run, 1'b0);
    x = 8'd159;
    cyc(3);
    check("paused_no_flip", dir_x, 1'b1);
    check("paused_bcnt", bounce_count, 16'd40);
    pause = 1'b0;
    x = 8'd80;
    cyc(3);
    pause = 1'b1;
    cyc(3);
    check("resume_state", state_o, 2'd2);
    check("resume_run", run, 1'b1);

    // wrap recovery
    x = 8'd200;
    cyc(1);
    check("wrap_dir_x", dir_x, 1'b0);
    check("wrap_bounce", bounce, 1'b1);
    check("wrap_bcnt", bounce_count, 16'd41);
    x = 8'd80;

    // stop
    stop = 1'b1;
    cyc(1);
    check("stop_state", state_o, 2'd0);
    check("stop_run", run, 1'b0);
    stop = 1'b0;

    // second serve uses the inverted toggle
    start = 1'b0;
    cyc(3);
    start = 1'b1;
    cyc(3);
    check("serve2_state", state_o, 2'd1);
    check("serve2_dir_x", dir_x, 1'b1);
    check("serve2_speed", speed, 2'd3);
    check("serve2_bcnt", bounce_count, 16'd0);
    serve_to_play();

    // asynchronous reset mid-play
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", state_o, 2'd0);
    check("arst_run", run, 1'b0);
    check("arst_dir", {dir_x, dir_y}, 2'b11);
    check("arst_speed", speed, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
